// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with mid-bit sampling, false-start rejection and framing check.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop bits and report parity_err.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic                 rx_meta, rxs;
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr, perr, perr_out, armed;
    logic                 at_end;

    assign at_end = tick_cnt == T_END;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] AFTER_DATA = PARITY;
    assign parity_err = perr_out;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
    assign parity_err = 1'b0;
`endif

    // armed requires rxs to be seen high in IDLE, so a held-low break cannot retrigger START
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            perr_out  <= 1'b0;
            ferr      <= 1'b0;
            perr      <= 1'b0;
            armed     <= 1'b1;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            perr_out  <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (rxs) armed <= 1'b1;
                        else if (armed) begin
                            armed <= 1'b0;
                            state <= START;
                        end
                    end
                    START: begin
                        if (tick_cnt == T_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            ferr     <= 1'b0;
                            perr     <= 1'b0;
                            armed    <= rxs;
                            state    <= rxs ? IDLE : DATA;
                        end else tick_cnt <= tick_cnt + 1'b1;
                    end
                    DATA: begin
                        if (at_end) begin
                            tick_cnt <= '0;
                            shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                            bit_cnt  <= bit_cnt == B_LAST ? '0 : bit_cnt + 1'b1;
                            if (bit_cnt == B_LAST) state <= AFTER_DATA;
                        end else tick_cnt <= tick_cnt + 1'b1;
                    end
                    PARITY: begin
                        if (at_end) begin
                            tick_cnt <= '0;
                            perr     <= ^shreg ^ rxs ^ (PARITY_ODD != 0);
                            state    <= STOP;
                        end else tick_cnt <= tick_cnt + 1'b1;
                    end
                    STOP: begin
                        if (at_end) begin
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (!rxs) ferr <= 1'b1;
                            if (bit_cnt == S_LAST) begin
                                data      <= shreg;
                                valid     <= 1'b1;
                                frame_err <= ferr | !rxs;
                                perr_out  <= perr;
                                armed     <= rxs;
                                bit_cnt   <= '0;
                                state     <= IDLE;
                            end
                        end else tick_cnt <= tick_cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
